// File: rtl/fwvip_wb_pkg.sv
// Shared constants for the Wishbone classic initiator: FSM encoding and helpers.
package fwvip_wb_pkg;

   // FSM encoding; kept as plain constants so older tools can consume it.
   typedef logic [0:0] wb_state_e;
   localparam wb_state_e IDLE = 1'b0;
   localparam wb_state_e BUS  = 1'b1;

   // Default geometry of the initiator.
   localparam int WB_ADDR_W_DFLT = 32;
   localparam int WB_DATA_W_DFLT = 32;
   localparam int WB_DEPTH_DFLT  = 4;
   localparam int WB_TMO_DFLT    = 256;

   // Pointer width for a queue of the given depth: one extra bit tells full from empty.
   function automatic int wb_ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fwvip_wb_fifo.sv
// First-word fall-through FIFO with wrap-bit pointers; used for commands and responses.
module fwvip_wb_fifo
   import fwvip_wb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = wb_ptr_w(DEPTH);

   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // Full when the wrap bits differ and the index bits match.
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign count    = wr_ptr_q - rd_ptr_q;
   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign pop_data = mem_q[rd_ptr_q[AW-1:0]];

   // Next pointer values.
   always_comb begin
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
   end

   // Pointer registers; reset empties the queue.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage; contents are only visible through a valid pointer, so no reset.
   always_ff @(posedge clock) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
   end

endmodule

// File: rtl/fwvip_wb_initiator_core.sv
// Wishbone classic initiator: queues commands, runs one classic cycle per command,
// returns in-order responses with bus-error and timeout status.
module fwvip_wb_initiator_core
   import fwvip_wb_pkg::*;
#(
   parameter int ADDR_WIDTH     = WB_ADDR_W_DFLT,
   parameter int DATA_WIDTH     = WB_DATA_W_DFLT,
   parameter int CMD_DEPTH      = WB_DEPTH_DFLT,
   parameter int RSP_DEPTH      = WB_DEPTH_DFLT,
   parameter int TIMEOUT_CYCLES = WB_TMO_DFLT
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [ADDR_WIDTH-1:0]   cmd_adr,
   input  logic                    cmd_we,
   input  logic [DATA_WIDTH/8-1:0] cmd_sel,
   input  logic [DATA_WIDTH-1:0]   cmd_dat,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [DATA_WIDTH-1:0]   rsp_dat,
   output logic                    rsp_err,
   output logic                    rsp_tmo,
   output logic                    cyc,
   output logic                    stb,
   output logic                    we,
   output logic [ADDR_WIDTH-1:0]   adr,
   output logic [DATA_WIDTH/8-1:0] sel,
   output logic [DATA_WIDTH-1:0]   dat_w,
   input  logic [DATA_WIDTH-1:0]   dat_r,
   input  logic                    ack,
   input  logic                    err,
   output logic                    busy
);

   localparam int SEL_W = DATA_WIDTH / 8;
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1) + 1;
   // Last counter value of a BUS phase before the timeout fires.
   localparam logic [TW-1:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? '0 : TW'(TIMEOUT_CYCLES - 1);

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] adr;
      logic                  we;
      logic [SEL_W-1:0]      sel;
      logic [DATA_WIDTH-1:0] dat;
   } cmd_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] dat;
      logic                  err;
      logic                  tmo;
   } rsp_t;

   cmd_t                     cmd_in, cmd_head;
   rsp_t                     rsp_in, rsp_head;
   logic                     cmd_full, cmd_empty, cmd_pop;
   logic                     rsp_full, rsp_empty, rsp_push;
   logic [$clog2(CMD_DEPTH):0] cmd_count;
   logic [$clog2(RSP_DEPTH):0] rsp_count;

   wb_state_e                state_q, state_d;
   logic                     cyc_q, cyc_d;
   logic                     we_q, we_d;
   logic [ADDR_WIDTH-1:0]    adr_q, adr_d;
   logic [SEL_W-1:0]         sel_q, sel_d;
   logic [DATA_WIDTH-1:0]    dat_w_q, dat_w_d;
   logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
   logic                     tmo_hit;

   assign cmd_in = '{adr: cmd_adr, we: cmd_we, sel: cmd_sel, dat: cmd_dat};

   fwvip_wb_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (cmd_valid && cmd_ready),
      .push_data (cmd_in),
      .pop       (cmd_pop),
      .pop_data  (cmd_head),
      .full      (cmd_full),
      .empty     (cmd_empty),
      .count     (cmd_count)
   );

   fwvip_wb_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (rsp_push),
      .push_data (rsp_in),
      .pop       (rsp_ready),
      .pop_data  (rsp_head),
      .full      (rsp_full),
      .empty     (rsp_empty),
      .count     (rsp_count)
   );

   assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_cnt_q == TMO_LAST);

   // Issue / terminate FSM. Issue happens only from IDLE, where nothing is in flight,
   // so a free response slot reduces to "response FIFO not full".
   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      adr_d     = adr_q;
      sel_d     = sel_q;
      dat_w_d   = dat_w_q;
      tmo_cnt_d = tmo_cnt_q;
      cmd_pop   = 1'b0;
      rsp_push  = 1'b0;
      rsp_in    = '0;
      case (state_q)
         IDLE: begin
            if (!cmd_empty && !rsp_full) begin
               state_d   = BUS;
               cyc_d     = 1'b1;
               cmd_pop   = 1'b1;
               we_d      = cmd_head.we;
               adr_d     = cmd_head.adr;
               sel_d     = cmd_head.sel;
               dat_w_d   = cmd_head.dat;
               tmo_cnt_d = '0;
            end
         end
         BUS: begin
            if (ack || err || tmo_hit) begin
               state_d    = IDLE;
               cyc_d      = 1'b0;
               rsp_push   = 1'b1;
               // err beats ack; ack beats a same-cycle timeout.
               rsp_in.err = err || (tmo_hit && !ack);
               rsp_in.tmo = tmo_hit && !ack && !err;
               rsp_in.dat = (ack && !err && !we_q) ? dat_r : '0;
            end else begin
               tmo_cnt_d = tmo_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, bus-issue registers and timeout counter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         adr_q     <= '0;
         sel_q     <= '0;
         dat_w_q   <= '0;
         tmo_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         adr_q     <= adr_d;
         sel_q     <= sel_d;
         dat_w_q   <= dat_w_d;
         tmo_cnt_q <= tmo_cnt_d;
      end
   end

   assign cmd_ready = !cmd_full;
   assign rsp_valid = !rsp_empty;
   // Response fields read as zero while nothing is queued.
   assign rsp_dat   = rsp_valid ? rsp_head.dat : '0;
   assign rsp_err   = rsp_valid && rsp_head.err;
   assign rsp_tmo   = rsp_valid && rsp_head.tmo;
   assign cyc       = cyc_q;
   assign stb       = cyc_q;
   assign we        = we_q;
   assign adr       = adr_q;
   assign sel       = sel_q;
   assign dat_w     = dat_w_q;
   assign busy      = (cmd_count != '0) || (rsp_count != '0) || (state_q == BUS);

endmodule

// File: tb/tb_fwvip_wb_initiator_core.sv
// Bench for the Wishbone initiator: directed scenarios plus random traffic, checked
// against a queue-level model of the command/response flow and a behavioural slave.
module tb_fwvip_wb_initiator_core;

   localparam int AW = 32, DW = 32, SW = 4, CD = 4, RD = 2, TMO = 16;

   logic          clock = 1'b0, reset_n = 1'b0;
   logic          cmd_valid = 1'b0, cmd_ready;
   logic [AW-1:0] cmd_adr = '0;
   logic          cmd_we = 1'b0;
   logic [SW-1:0] cmd_sel = '0;
   logic [DW-1:0] cmd_dat = '0;
   logic          rsp_valid, rsp_ready = 1'b0;
   logic [DW-1:0] rsp_dat;
   logic          rsp_err, rsp_tmo;
   logic          cyc, stb, we;
   logic [AW-1:0] adr;
   logic [SW-1:0] sel;
   logic [DW-1:0] dat_w, dat_r = '0;
   logic          ack = 1'b0, err = 1'b0;
   logic          busy;

   fwvip_wb_initiator_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CMD_DEPTH(CD),
                             .RSP_DEPTH(RD), .TIMEOUT_CYCLES(TMO)) dut (
      .clock(clock), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_adr(cmd_adr), .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_err(rsp_err),
      .rsp_tmo(rsp_tmo), .cyc(cyc), .stb(stb), .we(we), .adr(adr), .sel(sel),
      .dat_w(dat_w), .dat_r(dat_r), .ack(ack), .err(err), .busy(busy));

   always #5 clock = ~clock;

   typedef struct { logic [AW-1:0] adr; logic we; logic [SW-1:0] sel; logic [DW-1:0] dat; } cmd_s;
   typedef struct { logic [DW-1:0] dat; logic err; logic tmo; } rsp_s;

   cmd_s cmd_q[$];        // accepted, not yet issued
   rsp_s rsp_q[$];        // responses waiting in the initiator
   cmd_s cur, p_cmd, nullc;
   rsp_s p_rsp, last_pop;
   bit   exp_cyc, p_push, p_issue, p_term, p_rpop;
   int   cmd_cnt, rsp_cnt, stb_cnt, last_len, n_rise, idle_cnt, step_no, push_step, rise_step;
   int   gaps[$];
   bit   slv_rand, slv_hold, slv_fix, rr_g, rr_rand;
   int   slv_kind, slv_wait;         // kind: 0 ack, 1 err, 2 silent, 3 ack+err
   logic [DW-1:0] slv_fixdat;
   int   n_err = 0, n_chk = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic cmd_s mk(input logic [AW-1:0] a, input logic w, input logic [SW-1:0] s,
                               input logic [DW-1:0] d);
      cmd_s c;
      c.adr = a; c.we = w; c.sel = s; c.dat = d;
      return c;
   endfunction

   // One clock: account for the last edge, check outputs, play the slave, drive inputs.
   task automatic step(input bit v, input cmd_s c);
      bit resp, rr;
      @(negedge clock);
      step_no++;
      if (p_push) cmd_q.push_back(p_cmd);
      if (p_issue) begin cur = cmd_q.pop_front(); exp_cyc = 1'b1; end
      if (p_rpop) last_pop = rsp_q.pop_front();
      if (p_term) begin rsp_q.push_back(p_rsp); exp_cyc = 1'b0; end
      cmd_cnt = cmd_q.size();
      rsp_cnt = rsp_q.size();
      chk("cyc", cyc, exp_cyc);
      chk("stb", stb, exp_cyc);
      chk("cmd_ready", cmd_ready, cmd_cnt < CD);
      chk("rsp_valid", rsp_valid, rsp_cnt > 0);
      chk("busy", busy, (cmd_cnt > 0) || (rsp_cnt > 0) || exp_cyc);
      if (rsp_cnt > 0) begin
         chk("rsp_dat", rsp_dat, rsp_q[0].dat);
         chk("rsp_err", rsp_err, rsp_q[0].err);
         chk("rsp_tmo", rsp_tmo, rsp_q[0].tmo);
      end
      p_term = 1'b0;
      ack = 1'b0; err = 1'b0;
      dat_r = slv_fix ? slv_fixdat : DW'($urandom);
      if (exp_cyc) begin
         if (stb_cnt == 0) begin
            n_rise++; rise_step = step_no; gaps.push_back(idle_cnt);
            if (slv_rand) begin
               int k;
               k = $urandom_range(0, 19);
               slv_kind = (k < 14) ? 0 : (k < 17) ? 1 : (k < 19) ? 3 : 2;
               slv_wait = $urandom_range(0, 4);
            end
         end
         stb_cnt++;
         idle_cnt = 0;
         chk("adr", adr, cur.adr);
         chk("we", we, cur.we);
         chk("sel", sel, cur.sel);
         chk("dat_w", dat_w, cur.dat);
         resp = !slv_hold && (slv_kind != 2) && (stb_cnt > slv_wait);
         ack = resp && (slv_kind == 0 || slv_kind == 3);
         err = resp && (slv_kind == 1 || slv_kind == 3);
         if (resp || stb_cnt == TMO) begin
            p_term = 1'b1;
            if (err)      p_rsp = '{dat: '0, err: 1'b1, tmo: 1'b0};
            else if (ack) p_rsp = '{dat: cur.we ? '0 : dat_r, err: 1'b0, tmo: 1'b0};
            else          p_rsp = '{dat: '0, err: 1'b1, tmo: 1'b1};
            last_len = stb_cnt;
            stb_cnt = 0;
         end
      end else begin
         idle_cnt++;
      end
      rr = rr_rand ? ($urandom_range(0, 3) != 0) : rr_g;
      cmd_valid = v; cmd_adr = c.adr; cmd_we = c.we; cmd_sel = c.sel; cmd_dat = c.dat;
      rsp_ready = rr;
      p_push  = v && (cmd_cnt < CD);
      p_cmd   = c;
      if (p_push) push_step = step_no;
      p_issue = !exp_cyc && (cmd_cnt > 0) && (rsp_cnt < RD);
      p_rpop  = rr && (rsp_cnt > 0);
   endtask

   task automatic push(input cmd_s c);
      int n;
      n = 0;
      do begin step(1'b1, c); n++; end while (!p_push && n < 200);
      if (!p_push) chk("push_accept", 0, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, nullc);
   endtask

   task automatic drain();
      int n;
      n = 0;
      do begin step(1'b0, nullc); n++; end
      while (!(cmd_cnt == 0 && rsp_cnt == 0 && !exp_cyc && !p_push) && n < 3000);
      if (n >= 3000) chk("drain_timeout", 0, 1);
   endtask

   // Asynchronous reset in the middle of a clock phase.
   task automatic hit_reset();
      @(posedge clock);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_cyc", cyc, 0);
      chk("rst_stb", stb, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      cmd_q.delete(); rsp_q.delete();
      exp_cyc = 0; p_push = 0; p_issue = 0; p_term = 0; p_rpop = 0; stb_cnt = 0;
      cmd_valid = 0; ack = 0; err = 0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0;
      nullc = mk('0, 1'b0, '0, '0);
      slv_rand = 0; slv_hold = 0; slv_fix = 0; rr_g = 1; rr_rand = 0;
      slv_kind = 0; slv_wait = 0; slv_fixdat = '0;
      #3;
      chk("reset_cyc", cyc, 0);       chk("reset_stb", stb, 0);
      chk("reset_we", we, 0);         chk("reset_adr", adr, 0);
      chk("reset_sel", sel, 0);       chk("reset_dat_w", dat_w, 0);
      chk("reset_rsp_valid", rsp_valid, 0);
      chk("reset_rsp_dat", rsp_dat, 0);
      chk("reset_rsp_err", rsp_err, 0); chk("reset_rsp_tmo", rsp_tmo, 0);
      chk("reset_busy", busy, 0);     chk("reset_cmd_ready", cmd_ready, 1);
      @(negedge clock);
      reset_n = 1'b1;

      // Write acked after 2 wait cycles.
      slv_kind = 0; slv_wait = 2;
      push(mk(32'h100, 1'b1, 4'hF, 32'hDEADBEEF));
      drain();
      chk("t1_stb_len", last_len, 3);
      chk("t1_err", last_pop.err, 0);
      chk("t1_dat", last_pop.dat, 0);

      // Read with fixed return data, and push-to-cyc latency.
      slv_wait = 0; slv_fix = 1; slv_fixdat = 32'h12345678;
      push(mk(32'h104, 1'b0, 4'hF, 32'h0));
      r0 = push_step;
      drain();
      chk("t2_latency", rise_step - r0, 2);
      chk("t2_dat", last_pop.dat, 32'h12345678);
      chk("t2_err", last_pop.err, 0);
      slv_fix = 0;

      // Fill the command queue behind a stalled slave, then release it.
      slv_hold = 1; r0 = n_rise;
      for (int i = 0; i < 5; i++)
         push(mk(32'h200 + 32'(4 * i), 1'($urandom_range(0, 1)), 4'($urandom), $urandom));
      step(1'b0, nullc);
      chk("t3_full", cmd_ready, 0);
      gaps.delete();
      slv_hold = 0;
      drain();
      chk("t3_bus_cycles", n_rise - r0, 5);
      chk("t3_gap_count", gaps.size(), 4);
      foreach (gaps[i]) chk("t3_idle_gap", gaps[i], 1);

      // Bus error on a write, then a silent slave hitting the timeout.
      slv_kind = 1; slv_wait = 1;
      push(mk(32'h400, 1'b1, 4'h3, 32'h55AA55AA));
      drain();
      chk("t4_err", last_pop.err, 1);
      chk("t4_tmo", last_pop.tmo, 0);
      slv_kind = 2;
      push(mk(32'h404, 1'b0, 4'hF, 32'h0));
      drain();
      chk("t4_tmo_len", last_len, TMO);
      chk("t4_tmo_err", last_pop.err, 1);
      chk("t4_tmo_tmo", last_pop.tmo, 1);

      // Response back-pressure limits issue to the response queue depth.
      slv_kind = 0; slv_wait = 0; rr_g = 0; r0 = n_rise;
      for (int i = 0; i < 4; i++) push(mk(32'h500 + 32'(4 * i), 1'b0, 4'hF, 32'h0));
      idle(20);
      chk("t5_issued_stalled", n_rise - r0, 2);
      chk("t5_cyc_low", cyc, 0);
      rr_g = 1;
      drain();
      chk("t5_issued_total", n_rise - r0, 4);

      // Reset in the middle of a bus cycle, then a clean read.
      slv_hold = 1;
      push(mk(32'h600, 1'b0, 4'hF, 32'h0));
      idle(3);
      hit_reset();
      slv_hold = 0; slv_fix = 1; slv_fixdat = 32'hCAFEF00D;
      push(mk(32'h300, 1'b0, 4'hF, 32'h0));
      drain();
      chk("t6_dat", last_pop.dat, 32'hCAFEF00D);
      chk("t6_err", last_pop.err, 0);
      slv_fix = 0;

      // Random traffic, random slave, random response back-pressure.
      slv_rand = 1; rr_rand = 1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 2) != 0)
            step(1'b1, mk($urandom, 1'($urandom_range(0, 1)), 4'($urandom), $urandom));
         else
            step(1'b0, nullc);
      end
      drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
